// File: rtl/f1_reaction_timer.sv
// F1 start-light reaction timer.
// Waits for the full light gantry (0xFF), then runs a pseudo-random
// lights-out delay and measures the driver's reaction time in 1 ms ticks.
// A press before lights-out is reported as a jump start.
module f1_reaction_timer #(
    parameter logic [7:0] MIN_DELAY = 8'd20,
    parameter logic [6:0] LFSR_SEED = 7'h01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  lights,
    input  logic        tick,
    input  logic        trigger,
    output logic        lights_off,
    output logic [7:0]  delay_ms,
    output logic [15:0] reaction_ms,
    output logic        result_valid,
    output logic        jump_start
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_TIMING = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Maximal-length 7-bit LFSR step (taps 7,6); never leaves a nonzero seed.
    function automatic logic [6:0] lfsr_step(input logic [6:0] cur);
        lfsr_step = {cur[5:0], cur[6] ^ cur[5]};
    endfunction

    state_t      state_q, state_d;
    logic [6:0]  lfsr_q, lfsr_d;
    logic [7:0]  count_q, count_d;
    logic [15:0] rcnt_q, rcnt_d;
    logic        lights_off_q, lights_off_d;
    logic [7:0]  delay_ms_q, delay_ms_d;
    logic [15:0] reaction_ms_q, reaction_ms_d;
    logic        result_valid_q, result_valid_d;
    logic        jump_start_q, jump_start_d;
    logic [7:0]  load_val_s;

    // Delay for a new round; an 8-bit wrap to 0 naturally counts 256 ticks.
    assign load_val_s = MIN_DELAY + {1'b0, lfsr_q};

    // Next-state and output logic for the round FSM.
    always_comb begin
        state_d        = state_q;
        lfsr_d         = lfsr_step(lfsr_q);
        count_d        = count_q;
        rcnt_d         = rcnt_q;
        lights_off_d   = lights_off_q;
        delay_ms_d     = delay_ms_q;
        reaction_ms_d  = reaction_ms_q;
        result_valid_d = 1'b0;
        jump_start_d   = jump_start_q;

        case (state_q)
            ST_IDLE: begin
                // A press with any light lit is a jump start; with all lights
                // dark the press is simply ignored.
                if (trigger && (lights != 8'h00)) begin
                    state_d        = ST_DONE;
                    jump_start_d   = 1'b1;
                    result_valid_d = 1'b1;
                end else if (lights == 8'hFF) begin
                    state_d    = ST_DELAY;
                    count_d    = load_val_s;
                    delay_ms_d = load_val_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_DELAY: begin
                // Trigger wins over expiry in the same cycle.
                if (trigger) begin
                    state_d        = ST_DONE;
                    jump_start_d   = 1'b1;
                    lights_off_d   = 1'b0;
                    result_valid_d = 1'b1;
                end else if (tick) begin
                    count_d = count_q - 8'd1;
                    if (count_q == 8'd1) begin
                        state_d      = ST_TIMING;
                        lights_off_d = 1'b1;
                        rcnt_d       = 16'h0000;
                    end else begin
                        state_d = ST_DELAY;
                    end
                end else begin
                    state_d = ST_DELAY;
                end
            end

            ST_TIMING: begin
                // The reported time excludes a tick arriving with the press.
                if (trigger) begin
                    state_d        = ST_DONE;
                    reaction_ms_d  = rcnt_q;
                    jump_start_d   = 1'b0;
                    result_valid_d = 1'b1;
                end else if (tick && (rcnt_q != 16'hFFFF)) begin
                    rcnt_d = rcnt_q + 16'd1;
                end else begin
                    state_d = ST_TIMING;
                end
            end

            ST_DONE: begin
                if (lights == 8'h00) begin
                    state_d      = ST_IDLE;
                    lights_off_d = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end

            default: begin
                state_d      = ST_IDLE;
                lights_off_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            lfsr_q         <= LFSR_SEED;
            count_q        <= 8'h00;
            rcnt_q         <= 16'h0000;
            lights_off_q   <= 1'b0;
            delay_ms_q     <= 8'h00;
            reaction_ms_q  <= 16'h0000;
            result_valid_q <= 1'b0;
            jump_start_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            lfsr_q         <= lfsr_d;
            count_q        <= count_d;
            rcnt_q         <= rcnt_d;
            lights_off_q   <= lights_off_d;
            delay_ms_q     <= delay_ms_d;
            reaction_ms_q  <= reaction_ms_d;
            result_valid_q <= result_valid_d;
            jump_start_q   <= jump_start_d;
        end
    end

    assign lights_off   = lights_off_q;
    assign delay_ms     = delay_ms_q;
    assign reaction_ms  = reaction_ms_q;
    assign result_valid = result_valid_q;
    assign jump_start   = jump_start_q;

endmodule

// File: tb/tb_f1_reaction_timer.sv
// Scoreboard bench for f1_reaction_timer: stimulus pushes expected results,
// an independent monitor pops them whenever result_valid is seen.
module tb_f1_reaction_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  lights = 8'h00;
    logic        tick = 1'b0;
    logic        trigger = 1'b0;
    logic        lights_off;
    logic [7:0]  delay_ms;
    logic [15:0] reaction_ms;
    logic        result_valid;
    logic        jump_start;

    typedef struct packed {
        logic [15:0] react;
        logic        js;
        logic        lo;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic [6:0] m_lfsr;

    f1_reaction_timer dut (
        .clk          (clk),
        .rst          (rst),
        .lights       (lights),
        .tick         (tick),
        .trigger      (trigger),
        .lights_off   (lights_off),
        .delay_ms     (delay_ms),
        .reaction_ms  (reaction_ms),
        .result_valid (result_valid),
        .jump_start   (jump_start)
    );

    always #5 clk = ~clk;

    // Reference LFSR: 7-bit, x^7+x^6, reseeded to 1 by reset.
    always @(posedge clk) begin
        if (rst) m_lfsr <= 7'h01;
        else     m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every result_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && result_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got react=%0h js=%0b expected no pulse",
                         reaction_ms, jump_start);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("reaction_ms", {16'h0, reaction_ms}, {16'h0, e.react});
                chk("jump_start", {31'h0, jump_start}, {31'h0, e.js});
                chk("lights_off_at_result", {31'h0, lights_off}, {31'h0, e.lo});
            end
        end
    end

    // One clock: drive inputs after a falling edge, return at the next one.
    task automatic cyc(input logic tk, input logic tg);
        tick    = tk;
        trigger = tg;
        @(negedge clk);
        tick    = 1'b0;
        trigger = 1'b0;
    endtask

    task automatic expect_result(input logic [15:0] r, input logic j, input logic l);
        exp_t e;
        e.react = r;
        e.js    = j;
        e.lo    = l;
        exp_q.push_back(e);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_lights_off"}, {31'h0, lights_off}, 32'h0);
        chk({tag, "_delay_ms"}, {24'h0, delay_ms}, 32'h0);
        chk({tag, "_reaction_ms"}, {16'h0, reaction_ms}, 32'h0);
        chk({tag, "_result_valid"}, {31'h0, result_valid}, 32'h0);
        chk({tag, "_jump_start"}, {31'h0, jump_start}, 32'h0);
    endtask

    // Present the full gantry for one cycle and check the loaded delay.
    task automatic load_round(output int d);
        logic [7:0] ed;
        lights = 8'hFF;
        ed = 8'd20 + {1'b0, m_lfsr};
        cyc(1'b0, 1'b0);
        lights = 8'h00;
        chk("delay_ms_load", {24'h0, delay_ms}, {24'h0, ed});
        d = (ed == 8'h00) ? 256 : int'(ed);
    endtask

    // Tick down the delay; lights_off must rise on tick number d exactly.
    task automatic run_delay(input int d);
        for (int i = 1; i <= d; i++) begin
            cyc(1'b1, 1'b0);
            if (i == d - 1) chk("lights_off_before_expiry", {31'h0, lights_off}, 32'h0);
            if (i == d)     chk("lights_off_at_expiry", {31'h0, lights_off}, 32'h1);
        end
    endtask

    initial begin
        int d;
        logic [7:0] ramp;

        // Reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("reset");

        // Trigger with dark gantry is ignored
        cyc(1'b0, 1'b1);
        repeat (3) cyc(1'b0, 1'b0);
        chk_reset_vals("idle_trigger");

        // Ramp lights then run to lights-out, react after 150 ticks
        ramp = 8'h01;
        for (int i = 0; i < 7; i++) begin
            lights = ramp;
            cyc(1'b0, 1'b0);
            ramp = {ramp[6:0], 1'b1};
        end
        load_round(d);
        run_delay(d);
        repeat (150) cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
        expect_result(16'd150, 1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        chk("lights_off_cleared_idle", {31'h0, lights_off}, 32'h0);

        // Jump start while lights show 0x07
        lights = 8'h01; cyc(1'b0, 1'b0);
        lights = 8'h03; cyc(1'b0, 1'b0);
        lights = 8'h07;
        expect_result(16'd150, 1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        lights = 8'h00;
        repeat (2) cyc(1'b0, 1'b0);

        // Back in IDLE: new round loads, trigger on final delay tick
        load_round(d);
        for (int i = 1; i < d; i++) cyc(1'b1, 1'b0);
        expect_result(16'd150, 1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        chk("lights_off_jump_expiry", {31'h0, lights_off}, 32'h0);
        cyc(1'b0, 1'b0);

        // Trigger with tick in TIMING excludes that increment
        load_round(d);
        run_delay(d);
        repeat (5) cyc(1'b1, 1'b0);
        expect_result(16'd5, 1'b0, 1'b1);
        cyc(1'b1, 1'b1);
        repeat (2) cyc(1'b0, 1'b0);

        // Reset mid-TIMING beats trigger and tick
        load_round(d);
        run_delay(d);
        repeat (3) cyc(1'b1, 1'b0);
        rst = 1'b1;
        cyc(1'b1, 1'b1);
        rst = 1'b0;
        chk_reset_vals("mid_timing_rst");
        cyc(1'b0, 1'b0);

        // Saturation after 70000 ticks
        load_round(d);
        run_delay(d);
        repeat (70000) cyc(1'b1, 1'b0);
        expect_result(16'hFFFF, 1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        repeat (3) cyc(1'b0, 1'b0);

        // Every expected result must have been observed
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL missing_result: got none expected react=%0h js=%0b", e.react, e.js);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/f1_reaction_timer.md
F1_REACTION_TIMER -- requirements
Module: f1_reaction_timer

Interface
REQ-001 Parameter MIN_DELAY, default 8'd20: minimum lights-out delay in ticks.
REQ-002 Parameter LFSR_SEED, default 7'h01: LFSR value after reset; nonzero.
REQ-003 Port clk, input, 1: single clock; all state updates on posedge clk.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port lights, input, 8: light pattern from the upstream start-light sequencer (0x00, 0x01 ... 0xFF).
REQ-006 Port tick, input, 1: one-cycle 1 ms strobe.
REQ-007 Port trigger, input, 1: driver button, synchronised and single-cycle per press.
REQ-008 Port lights_off, output, 1: high from lights-out until the round ends.
REQ-009 Port delay_ms, output, 8: delay loaded for the current round.
REQ-010 Port reaction_ms, output, 16: last measured reaction time in ticks.
REQ-011 Port result_valid, output, 1: one-cycle pulse when reaction_ms or jump_start updates.
REQ-012 Port jump_start, output, 1: high when the last round ended in a jump start.

Function
REQ-013 Internal 7-bit LFSR SHALL shift every clk (q <= {q[5:0], q[6]^q[5]}), period 127, and never reach 0.
REQ-014 FSM states SHALL be IDLE, DELAY, TIMING and DONE.
REQ-015 IDLE, trigger=1 and lights!=0x00: go to DONE, set jump_start=1, pulse result_valid.
REQ-016 IDLE, lights==0xFF (no trigger): go to DELAY, load count and delay_ms with MIN_DELAY + LFSR (8-bit, wraps mod 256).
REQ-017 IDLE, trigger=1 and lights==0x00: ignore the trigger.
REQ-018 DELAY: on each tick decrement count; on a tick with count==1, go to TIMING, set lights_off=1 and clear the reaction counter.
REQ-019 Loaded delay of 0 (wrap): treat as 256 ticks.
REQ-020 DELAY, trigger=1 (including the expiry cycle): go to DONE with jump_start=1, lights_off=0, pulse result_valid; trigger has priority over expiry.
REQ-021 TIMING: on each tick increment the reaction counter, saturating at 0xFFFF.
REQ-022 TIMING, trigger=1: latch the counter value before that cycle's increment into reaction_ms, set jump_start=0, pulse result_valid, go to DONE.
REQ-023 DONE: hold lights_off, reaction_ms and jump_start; on lights==0x00 go to IDLE and clear lights_off.
REQ-024 DONE: ignore trigger and tick.
REQ-025 result_valid SHALL be high exactly one cycle per round; latency from trigger is 1 cycle (registered).
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 rst=1 SHALL force, at the next edge: state=IDLE, LFSR=LFSR_SEED, count=0, lights_off=0, delay_ms=0x00, reaction_ms=0x0000, result_valid=0, jump_start=0.
REQ-028 rst SHALL take priority over all inputs in the same cycle, including mid-DELAY or mid-TIMING.

Verification
REQ-029 After reset, hold lights=0x00 and pulse trigger -> no result_valid, all outputs stay at reset values.
REQ-030 Ramp lights 0x00 to 0xFF, then no trigger -> delay_ms = 20 + LFSR at load; lights_off rises exactly on tick number delay_ms after load.
REQ-031 In TIMING, give 150 ticks then trigger -> reaction_ms=150, result_valid for 1 cycle, jump_start=0, lights_off stays 1.
REQ-032 Trigger while lights=0x07 -> jump_start=1, result_valid pulse, state DONE; lights back to 0x00 -> IDLE.
REQ-033 Trigger and final DELAY tick in the same cycle -> jump_start=1, lights_off stays 0; trigger and tick in the same TIMING cycle -> the increment is excluded.
REQ-034 rst mid-TIMING, and in a separate run 70000 ticks without trigger -> first gives all reset values next cycle; second saturates, then trigger -> reaction_ms=0xFFFF.
